// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-memory request, registered {instr, pc} towards decode.
// Optional misaligned-PC trap is built when IFETCH_MISALIGN_TRAP_EN is defined.
module instruction_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  input  logic              dec_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic              misaligned
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state;
  logic              squash;
  logic [DATA_W-1:0] hold_instr;
  logic [ADDR_W-1:0] fetch_addr;
  logic              hold_load;

  assign fetch_addr = {pc_in[ADDR_W-1:2], 2'b00};
  assign fetch_busy = (state != S_IDLE);

  // Only a live (non-squashed) response that decode cannot take yet is parked.
  assign hold_load = (state == S_WAIT) && imem_valid && dec_stall && !flush && !squash;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic pc_misaligned;
  assign pc_misaligned = (pc_in[1:0] != 2'b00);
`else
  logic unused_pc_low;
  assign unused_pc_low = ^pc_in[1:0];
  assign misaligned    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_out   <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misaligned  <= 1'b0;
`endif
    end else begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misaligned  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          squash <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (pc_misaligned) begin
            misaligned <= !flush;
            instr_pc   <= pc_in;
          end else begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_addr;
          end
`else
          state     <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= fetch_addr;
`endif
        end
        S_REQ: begin
          state <= S_WAIT;
          if (flush) squash <= 1'b1;
        end
        S_WAIT: begin
          if (imem_valid) begin
            squash <= 1'b0;
            // A squashed or same-cycle-flushed response is consumed and dropped.
            if (flush || squash) begin
              state <= S_IDLE;
            end else if (!dec_stall) begin
              instr_out   <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_HOLD;
            end
          end else if (flush) begin
            squash <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (!dec_stall) begin
            instr_out   <= hold_instr;
            instr_pc    <= imem_addr;
            instr_valid <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (hold_load) hold_instr <= imem_rdata;
  end

endmodule
